dfb_sched: RTL and testbench
============================

# dfb_sched

Round-robin scheduler that time-shares one `dfb` processing chain between `N_CH` independent audio streams. It arbitrates among per-channel sample requests and issues one 24-bit sample per handshake into the shared chain. It tags each issued sample with its channel ID and steers the returning samples back to the originating channel in order. It sits between the per-channel audio sources/sinks and a single in-order `dfb` chain.

## Interface
- `N_CH`, 4: number of requesting channels, 2..16.
- `DATA_W`, 24: sample width.
- `TAG_DEPTH`, 8: maximum samples in flight inside the chain; power of 2, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  N_CH  per-channel sample valid.
- `s_ready`  out  N_CH  per-channel accept.
- `s_data`  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- `dp_out_valid`  out  1  sample to shared chain.
- `dp_out_ready`  in  1  chain accepts.
- `dp_out_data`  out  DATA_W  issued sample.
- `dp_in_valid`  in  1  processed sample from chain.
- `dp_in_ready`  out  1  scheduler accepts processed sample.
- `dp_in_data`  in  DATA_W  processed sample.
- `m_valid`  out  N_CH  per-channel result valid.
- `m_ready`  in  N_CH  per-channel sink ready.
- `m_data`  out  N_CH*DATA_W  result; same packing as `s_data`.
- `inflight`  out  $clog2(TAG_DEPTH)+1  tags currently outstanding.
- `err_orphan`  out  1  sticky; chain presented a sample with no outstanding tag.

## Operation
- Handshake is valid/ready on every port. A transfer happens when valid && ready on a rising edge. Valid never depends combinationally on ready of the same port.
- Issue stage uses one output register (`dp_out_valid/data`) plus a round-robin pointer `rr_ptr`.
- `load` = (!dp_out_valid || dp_out_ready) && !tag_full.
- Grant goes to the first k with `s_valid[k]`, searching from `rr_ptr` upward and wrapping modulo N_CH. Only the granted channel sees `s_ready[k]` = `load`; all other channels see 0.
- On a grant transfer:
  - the output register loads `s_data[k]` and `dp_out_valid` is set;
  - k is pushed into the tag FIFO;
  - `rr_ptr` becomes (k+1) mod N_CH.
- If `dp_out_ready` is true and there is no grant, `dp_out_valid` clears.
- Tag FIFO holds channel IDs, width $clog2(N_CH), depth TAG_DEPTH. Its head is `tag_head`.
- Return path is combinational pass-through:
  - `m_data` carries `dp_in_data` on every channel slice;
  - `m_valid[k]` = dp_in_valid && !tag_empty && tag_head==k;
  - `dp_in_ready` = !tag_empty && m_ready[tag_head].
- A return handshake pops the FIFO.
- Full: no push, so all `s_ready` are 0. This holds even if a pop occurs in the same cycle. Push and pop together are otherwise legal, and the count is unchanged.
- Empty with `dp_in_valid`=1: `dp_in_ready` stays 0, `err_orphan` sets and remains set until reset.
- `inflight` = FIFO occupancy, 0..TAG_DEPTH.

## Timing
- Reset values (async assert, sync-clean deassert):
  - `dp_out_valid`=0, `dp_out_data`=0;
  - `rr_ptr`=0;
  - FIFO empty, `inflight`=0;
  - `err_orphan`=0.
- Combinational outputs follow from these register values: `s_ready`=0 while full, `m_valid`=0 and `dp_in_ready`=0 while empty.
- Issue latency: an `s_*` handshake at edge n gives `dp_out_valid` high after edge n. Throughput is 1 sample/cycle while the chain stays ready and the FIFO is not full.
- Return latency: 0 cycles scheduler-internal (pass-through).
- A stalled `dp_out_ready` holds `dp_out_data` stable. No sample is dropped or duplicated.
- Reset mid-operation: all tags and the held sample are discarded. The chain must be reset in the same cycle by the system.
- The tag is pushed when the sample enters the output register, so the FIFO counts held samples as in flight. The chain must be strictly in-order, one output per input.

## Structure
- Package `dfb_sched_pkg`:
  - `DFB_DATA_W`=24;
  - default `N_CH`/`TAG_DEPTH` constants;
  - function `rr_pick(req, ptr)` returning the grant index and a found flag.
- One sub-module, `dfb_tag_fifo`: synchronous FIFO, parameters WIDTH and DEPTH, with full/empty/count outputs and async active-low reset.
- Top `dfb_sched`: arbiter, output register, return steering, error flag.

## Test plan
- Single channel: ch2 sends 0x000001..0x000005 through a 3-cycle in-order delay chain, sinks always ready. Expect `m_valid[2]` only, data in order, `inflight` peaks at 4, no errors.
- Fairness: all 4 channels continuously valid, chain always ready. Expect grant order 0,1,2,3,0,1… with exactly one issue per cycle after the first.
- Back-pressure: hold `dp_out_ready`=0 for 5 cycles with ch1 valid. Expect `dp_out_data` stable, `s_ready[1]`=1 for one cycle only, then 0 until release.
- Full: TAG_DEPTH=8 with the chain never returning. Expect exactly 8 issues, then all `s_ready`=0 and `inflight`=8. Release one return: the push does not happen that cycle, then the next sample issues.
- Sink stall: head tag=3 and `m_ready[3]`=0 for 4 cycles. Expect `dp_in_ready`=0 throughout and other channels' results blocked. Order is preserved after release.
- Orphan and reset: `dp_in_valid`=1 while empty sets `err_orphan`=1 and keeps `dp_in_ready`=0. Asserting `rstn` low mid-stream clears `err_orphan`, `inflight` and `dp_out_valid` immediately.

Source files
------------

// File: rtl/dfb_sched_pkg.sv
// rtl/dfb_sched_pkg.sv - shared constants, types and round-robin pick for dfb_sched
package dfb_sched_pkg;

    localparam int DFB_DATA_W    = 24;
    localparam int DFB_N_CH      = 4;
    localparam int DFB_TAG_DEPTH = 8;
    localparam int RR_MAX_CH     = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping at n_ch; ptr < n_ch is assumed.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int                   n_ch);
        rr_pick_t pick;
        int       k;
        pick = '0;
        for (int i = 0; i < RR_MAX_CH; i++) begin
            k = int'(ptr) + i;
            if (k >= n_ch) k = k - n_ch;
            if (i < n_ch && !pick.found && req[k[3:0]]) begin
                pick.found = 1'b1;
                pick.idx   = k[3:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dfb_tag_fifo.sv
// rtl/dfb_tag_fifo.sv - synchronous FIFO of channel tags for samples in flight
module dfb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dfb_sched.sv
// rtl/dfb_sched.sv - round-robin scheduler sharing one in-order dfb chain among N_CH streams
module dfb_sched
    import dfb_sched_pkg::*;
#(
    parameter int N_CH      = DFB_N_CH,
    parameter int DATA_W    = DFB_DATA_W,
    parameter int TAG_DEPTH = DFB_TAG_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_CH-1:0]              s_valid,
    output logic [N_CH-1:0]              s_ready,
    input  logic [N_CH*DATA_W-1:0]       s_data,
    output logic                         dp_out_valid,
    input  logic                         dp_out_ready,
    output logic [DATA_W-1:0]            dp_out_data,
    input  logic                         dp_in_valid,
    output logic                         dp_in_ready,
    input  logic [DATA_W-1:0]            dp_in_data,
    output logic [N_CH-1:0]              m_valid,
    input  logic [N_CH-1:0]              m_ready,
    output logic [N_CH*DATA_W-1:0]       m_data,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    output logic                         err_orphan
);

    localparam int TW = $clog2(N_CH);

    rr_pick_t      pick;
    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] gnt_ch;
    logic [TW-1:0] tag_head;
    logic          load;
    logic          grant;
    logic          tag_full;
    logic          tag_empty;
    logic          pop;

    // A full tag FIFO blocks issue even when a return frees a slot this cycle.
    always_comb begin
        pick    = rr_pick(RR_MAX_CH'(s_valid), 4'(rr_ptr), N_CH);
        gnt_ch  = TW'(pick.idx);
        load    = (!dp_out_valid || dp_out_ready) && !tag_full;
        grant   = load && pick.found;
        s_ready = '0;
        if (pick.found) s_ready[gnt_ch] = load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_out_valid <= 1'b0;
            dp_out_data  <= '0;
            rr_ptr       <= '0;
        end else if (grant) begin
            dp_out_valid <= 1'b1;
            dp_out_data  <= s_data[gnt_ch*DATA_W +: DATA_W];
            rr_ptr       <= (gnt_ch == TW'(N_CH-1)) ? '0 : gnt_ch + 1'b1;
        end else if (dp_out_ready) begin
            dp_out_valid <= 1'b0;
        end
    end

    dfb_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant),
        .din   (gnt_ch),
        .pop   (pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    // Returns are steered combinationally to the channel at the head of the tag FIFO.
    assign dp_in_ready = !tag_empty && m_ready[tag_head];
    assign pop         = dp_in_valid && dp_in_ready;
    assign m_data      = {N_CH{dp_in_data}};

    always_comb begin
        m_valid = '0;
        if (dp_in_valid && !tag_empty) m_valid[tag_head] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          err_orphan <= 1'b0;
        else if (dp_in_valid && tag_empty)  err_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_dfb_sched.sv
// tb/tb_dfb_sched.sv - directed self-checking bench for dfb_sched
module tb_dfb_sched;

    localparam int NC = 4;
    localparam int DW = 24;
    localparam int TD = 8;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NC-1:0]            s_valid;
    logic [NC-1:0]            s_ready;
    logic [NC*DW-1:0]         s_data;
    logic                     dp_out_valid;
    logic                     dp_out_ready;
    logic [DW-1:0]            dp_out_data;
    logic                     dp_in_valid;
    logic                     dp_in_ready;
    logic [DW-1:0]            dp_in_data;
    logic [NC-1:0]            m_valid;
    logic [NC-1:0]            m_ready;
    logic [NC*DW-1:0]         m_data;
    logic [$clog2(TD):0]      inflight;
    logic                     err_orphan;

    int n_chk  = 0;
    int n_fail = 0;

    logic          use_chain   = 1'b0;
    logic          tb_in_valid = 1'b0;
    logic [DW-1:0] tb_in_data  = '0;
    logic [2:0]    pv  = '0;
    logic [DW-1:0] pd0 = '0;
    logic [DW-1:0] pd1 = '0;
    logic [DW-1:0] pd2 = '0;

    always #5 clk = ~clk;

    // Three-stage in-order delay chain standing in for the dfb.
    always @(posedge clk) begin
        pv  <= {pv[1:0], use_chain && dp_out_valid && dp_out_ready};
        pd0 <= dp_out_data;
        pd1 <= pd0;
        pd2 <= pd1;
    end

    assign dp_in_valid = use_chain ? pv[2] : tb_in_valid;
    assign dp_in_data  = use_chain ? pd2   : tb_in_data;

    dfb_sched #(.N_CH(NC), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .dp_out_data  (dp_out_data),
        .dp_in_valid  (dp_in_valid),
        .dp_in_ready  (dp_in_ready),
        .dp_in_data   (dp_in_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int sent;
    int nret;
    int peak;

    initial begin
        s_valid      = '0;
        s_data       = '0;
        dp_out_ready = 1'b1;
        m_ready      = '1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(dp_out_valid), 64'd0);
        chk("rst_out_data",  64'(dp_out_data),  64'd0);
        chk("rst_inflight",  64'(inflight),     64'd0);
        chk("rst_orphan",    64'(err_orphan),   64'd0);
        chk("rst_m_valid",   64'(m_valid),      64'd0);
        chk("rst_in_ready",  64'(dp_in_ready),  64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // single channel through the delay chain
        use_chain = 1'b1;
        sent = 0; nret = 0; peak = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s_valid = (sent < 5) ? 4'b0100 : 4'b0000;
            s_data  = '0;
            s_data[2*DW +: DW] = DW'(sent + 1);
            #1;
            if (s_valid[2] && s_ready[2]) sent++;
            if (int'(inflight) > peak) peak = int'(inflight);
            if (m_valid != '0) begin
                chk("single_m_valid", 64'(m_valid), 64'b0100);
                chk("single_data", 64'(m_data[2*DW +: DW]), 64'(nret + 1));
                nret++;
            end
        end
        chk("single_sent",     64'(sent),       64'd5);
        chk("single_returns",  64'(nret),       64'd5);
        chk("single_peak",     64'(peak),       64'd4);
        chk("single_orphan",   64'(err_orphan), 64'd0);
        chk("single_inflight", 64'(inflight),   64'd0);

        // orphan return while empty
        @(negedge clk);
        use_chain   = 1'b0;
        s_valid     = '0;
        tb_in_valid = 1'b1;
        tb_in_data  = 24'h123456;
        #1;
        chk("orphan_in_ready", 64'(dp_in_ready), 64'd0);
        chk("orphan_m_valid",  64'(m_valid),     64'd0);
        chk("orphan_pre",      64'(err_orphan),  64'd0);
        @(negedge clk);
        tb_in_valid  = 1'b0;
        dp_out_ready = 1'b0;
        s_valid      = 4'b0001;
        s_data[0 +: DW] = 24'hABCDEF;
        #1;
        chk("orphan_set", 64'(err_orphan), 64'd1);

        // reset mid-stream with a held sample
        @(negedge clk);
        #1;
        chk("mid_out_valid", 64'(dp_out_valid), 64'd1);
        chk("mid_inflight",  64'(inflight),     64'd1);
        chk("mid_out_data",  64'(dp_out_data),  64'hABCDEF);
        chk("mid_orphan",    64'(err_orphan),   64'd1);
        rstn = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(dp_out_valid), 64'd0);
        chk("mrst_inflight",  64'(inflight),     64'd0);
        chk("mrst_orphan",    64'(err_orphan),   64'd0);
        chk("mrst_out_data",  64'(dp_out_data),  64'd0);
        s_valid      = '0;
        dp_out_ready = 1'b1;

        // fairness and fill to TAG_DEPTH with no returns
        @(negedge clk);
        rstn    = 1'b1;
        s_valid = '1;
        for (int k = 0; k < NC; k++) s_data[k*DW +: DW] = DW'(24'hA00000 + k);
        for (int i = 0; i < TD; i++) begin
            #1;
            chk("fair_s_ready",  64'(s_ready),  64'(1 << (i % NC)));
            chk("fair_inflight", 64'(inflight), 64'(i));
            if (i > 0) chk("fair_out_data", 64'(dp_out_data), 64'(24'hA00000 + (i - 1) % NC));
            @(negedge clk);
        end
        #1;
        chk("full_s_ready",  64'(s_ready),      64'd0);
        chk("full_inflight", 64'(inflight),     64'd8);
        chk("full_valid",    64'(dp_out_valid), 64'd1);
        chk("full_data",     64'(dp_out_data),  64'hA00003);
        @(negedge clk);
        #1;
        chk("full_drained",  64'(dp_out_valid), 64'd0);
        chk("full_s_ready2", 64'(s_ready),      64'd0);
        tb_in_valid = 1'b1;
        tb_in_data  = 24'h000005;
        #1;
        chk("full_pop_m_valid",  64'(m_valid),     64'b0001);
        chk("full_pop_in_ready", 64'(dp_in_ready), 64'd1);
        chk("full_pop_s_ready",  64'(s_ready),     64'd0);
        @(negedge clk);
        tb_in_valid = 1'b0;
        #1;
        chk("full_after_pop_inflight", 64'(inflight), 64'd7);
        chk("full_after_pop_s_ready",  64'(s_ready),  64'b0001);
        @(negedge clk);
        #1;
        chk("full_refill_inflight", 64'(inflight),    64'd8);
        chk("full_refill_s_ready",  64'(s_ready),     64'd0);
        chk("full_refill_data",     64'(dp_out_data), 64'hA00000);

        // sink stall on head tag 3; queue holds 1,2,3,0,1,2,3,0
        @(negedge clk);
        s_valid     = '0;
        tb_in_valid = 1'b1;
        #1;
        chk("sink_m_valid_1", 64'(m_valid),     64'b0010);
        chk("sink_in_ready",  64'(dp_in_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("sink_m_valid_2", 64'(m_valid), 64'b0100);
        @(negedge clk);
        m_ready = 4'b0111;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("stall_in_ready", 64'(dp_in_ready), 64'd0);
            chk("stall_m_valid",  64'(m_valid),     64'b1000);
            chk("stall_inflight", 64'(inflight),    64'd6);
            @(negedge clk);
        end
        m_ready = '1;
        #1;
        chk("release_in_ready", 64'(dp_in_ready), 64'd1);
        chk("release_m_valid",  64'(m_valid),     64'b1000);
        @(negedge clk);
        #1;
        chk("order_m_valid",  64'(m_valid),  64'b0001);
        chk("order_inflight", 64'(inflight), 64'd5);
        @(negedge clk);
        tb_in_valid = 1'b0;
        #1;
        chk("drain_inflight", 64'(inflight), 64'd4);

        // back-pressure on the chain with ch1 valid
        dp_out_ready = 1'b0;
        s_valid      = 4'b0010;
        s_data[1*DW +: DW] = 24'h111111;
        #1;
        chk("bp_first_ready", 64'(s_ready), 64'b0010);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) s_data[1*DW +: DW] = 24'h222222;
            #1;
            chk("bp_s_ready", 64'(s_ready),      64'd0);
            chk("bp_data",    64'(dp_out_data),  64'h111111);
            chk("bp_valid",   64'(dp_out_valid), 64'd1);
        end
        dp_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(s_ready), 64'b0010);
        @(negedge clk);
        #1;
        chk("bp_next_data", 64'(dp_out_data), 64'h222222);
        chk("bp_inflight",  64'(inflight),    64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
